control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 41 ++++
 rtl/control_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the microcode sequencer and the datapath: opcode/flag/run inputs
// to the sequencer, one-hot-ish control strobes and status back out.
interface control_sequencer_if;
  logic [4:0] OpCodeIn;
  logic       ZeroFlag;
  logic       Run;
  logic       Step;

  logic       PcOut;
  logic       PcInc;
  logic       PcIn;
  logic       MarIn;
  logic       RamOut;
  logic       RamIn;
  logic       InstructionRegIn;
  logic       InstructionRegOut;
  logic       ARegIn;
  logic       ARegOut;
  logic       BRegIn;
  logic       AluOut;
  logic       AluSub;
  logic       OutRegIn;

  logic [2:0] StepCount;
  logic       InstrDone;
  logic       Halted;

  // Sequencer side.
  modport master (
    input  OpCodeIn, ZeroFlag, Run, Step,
    output PcOut, PcInc, PcIn, MarIn, RamOut, RamIn, InstructionRegIn, InstructionRegOut,
           ARegIn, ARegOut, BRegIn, AluOut, AluSub, OutRegIn, StepCount, InstrDone, Halted
  );

  // Datapath side.
  modport slave (
    output OpCodeIn, ZeroFlag, Run, Step,
    input  PcOut, PcInc, PcIn, MarIn, RamOut, RamIn, InstructionRegIn, InstructionRegOut,
           ARegIn, ARegOut, BRegIn, AluOut, AluSub, OutRegIn, StepCount, InstrDone, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// T-state microcode sequencer for a small 8-bit CPU: common fetch in T0/T1, opcode-specific
// execute in T2..T4, and a sticky HALT state left only through reset.
module control_sequencer (
  input logic                 Clk,
  input logic                 Rst,
  control_sequencer_if.master bus
);

  // Encoding doubles as StepCount: T index for T0..T4, 7 for HALT.
  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StHalt = 3'd7
  } state_e;

  localparam logic [4:0] OpLda = 5'd1;
  localparam logic [4:0] OpSta = 5'd2;
  localparam logic [4:0] OpAdd = 5'd3;
  localparam logic [4:0] OpSub = 5'd4;
  localparam logic [4:0] OpLdi = 5'd5;
  localparam logic [4:0] OpJmp = 5'd6;
  localparam logic [4:0] OpJz  = 5'd7;
  localparam logic [4:0] OpOut = 5'd8;
  localparam logic [4:0] OpHlt = 5'd31;

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic       advance;
  logic       done;

  assign advance = bus.Run | bus.Step;

  always_comb begin
    bus.PcOut             = 1'b0;
    bus.PcInc             = 1'b0;
    bus.PcIn              = 1'b0;
    bus.MarIn             = 1'b0;
    bus.RamOut            = 1'b0;
    bus.RamIn             = 1'b0;
    bus.InstructionRegIn  = 1'b0;
    bus.InstructionRegOut = 1'b0;
    bus.ARegIn            = 1'b0;
    bus.ARegOut           = 1'b0;
    bus.BRegIn            = 1'b0;
    bus.AluOut            = 1'b0;
    bus.AluSub            = 1'b0;
    bus.OutRegIn          = 1'b0;
    bus.StepCount         = state_q;
    bus.Halted            = (state_q == StHalt);
    done                  = 1'b0;
    state_d               = state_q;
    opcode_d              = opcode_q;

    // Rst gating keeps strobes quiet while reset is held even with Run high.
    if (Rst && advance) begin
      unique case (state_q)
        StT0: begin
          bus.PcOut = 1'b1;
          bus.MarIn = 1'b1;
          state_d   = StT1;
        end
        StT1: begin
          bus.RamOut           = 1'b1;
          bus.InstructionRegIn = 1'b1;
          bus.PcInc            = 1'b1;
          opcode_d             = bus.OpCodeIn;
          state_d              = StT2;
        end
        StT2: begin
          case (opcode_q)
            OpLda, OpSta, OpAdd, OpSub: begin
              bus.InstructionRegOut = 1'b1;
              bus.MarIn             = 1'b1;
              state_d               = StT3;
            end
            OpLdi: begin
              bus.InstructionRegOut = 1'b1;
              bus.ARegIn            = 1'b1;
              done                  = 1'b1;
            end
            OpJmp: begin
              bus.InstructionRegOut = 1'b1;
              bus.PcIn              = 1'b1;
              done                  = 1'b1;
            end
            OpJz: begin
              bus.InstructionRegOut = bus.ZeroFlag;
              bus.PcIn              = bus.ZeroFlag;
              done                  = 1'b1;
            end
            OpOut: begin
              bus.ARegOut  = 1'b1;
              bus.OutRegIn = 1'b1;
              done         = 1'b1;
            end
            OpHlt:   state_d = StHalt;
            default: done = 1'b1;
          endcase
        end
        StT3: begin
          case (opcode_q)
            OpLda: begin
              bus.RamOut = 1'b1;
              bus.ARegIn = 1'b1;
              done       = 1'b1;
            end
            OpSta: begin
              bus.ARegOut = 1'b1;
              bus.RamIn   = 1'b1;
              done        = 1'b1;
            end
            OpAdd, OpSub: begin
              bus.RamOut = 1'b1;
              bus.BRegIn = 1'b1;
              bus.AluSub = (opcode_q == OpSub);
              state_d    = StT4;
            end
            default: done = 1'b1;
          endcase
        end
        StT4: begin
          bus.AluOut = 1'b1;
          bus.ARegIn = 1'b1;
          bus.AluSub = (opcode_q == OpSub);
          done       = 1'b1;
        end
        StHalt: state_d = StHalt;
        default: state_d = StT0;
      endcase
      if (done) state_d = StT0;
    end

    bus.InstrDone = done;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StT0;
      opcode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

endmodule
